multicycle_main_fsm: RTL and testbench

- Main control state machine for the multicycle RISC-V datapath.
- Sits directly upstream of ALU_decoder and drives its 2-bit ALUOp (00 add, 01 branch-sub, 10 funct-decoded).
- Sequences fetch, decode, execute, memory and writeback over several cycles, and drives all datapath mux selects and write strobes.
- Stalls on a memory-ready handshake and counts retired instructions.

---
 rtl/multicycle_main_fsm.sv | 160 ++++++++++++++++
 tb/tb_multicycle_main_fsm.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_main_fsm.sv
// Main control FSM for the multicycle RISC-V datapath: sequences fetch/decode/execute/
// memory/writeback, drives mux selects and strobes, and counts retired instructions.
module multicycle_main_fsm #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic             mem_ready,
    output logic [1:0]       ALUOp,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ResultSrc,
    output logic             AdrSrc,
    output logic             IRWrite,
    output logic             PCUpdate,
    output logic             Branch,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic             illegal_instr,
    output logic [CNT_W-1:0] instret,
    output logic [3:0]       state_o
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    state_t           r_state;
    state_t           w_next;
    logic             r_illegal;
    logic [CNT_W-1:0] r_instret;
    logic             w_unsupported;
    logic             w_retire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_illegal <= 1'b0;
            r_instret <= '0;
        end else begin
            r_state   <= w_next;
            r_illegal <= (r_state == S_DECODE) && w_unsupported;
            if (w_retire)
                r_instret <= r_instret + CNT_W'(1);
        end
    end

    always_comb begin
        w_next        = S_FETCH;
        w_unsupported = 1'b0;
        w_retire      = 1'b0;
        ALUOp         = 2'b00;
        ALUSrcA       = 2'b00;
        ALUSrcB       = 2'b00;
        ResultSrc     = 2'b00;
        AdrSrc        = 1'b0;
        IRWrite       = 1'b0;
        PCUpdate      = 1'b0;
        Branch        = 1'b0;
        RegWrite      = 1'b0;
        MemWrite      = 1'b0;
        case (r_state)
            S_FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = mem_ready;
                PCUpdate  = mem_ready;
                w_next    = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // Compute the branch target into ALUOut while the opcode is decoded.
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (opcode)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_EXECUTER;
                    OP_ITYPE:     w_next = S_EXECUTEI;
                    OP_BR:        w_next = S_BRANCH;
                    OP_JAL:       w_next = S_JAL;
                    default: begin
                        w_next        = S_FETCH;
                        w_unsupported = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                w_next  = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                w_next = mem_ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
                w_retire  = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                w_retire = mem_ready;
                w_next   = mem_ready ? S_FETCH : S_MEMWRITE;
            end
            S_EXECUTER: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b10;
                w_next  = S_ALUWB;
            end
            S_EXECUTEI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
                w_next  = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                w_retire = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA  = 2'b10;
                ALUOp    = 2'b01;
                Branch   = 1'b1;
                w_retire = 1'b1;
            end
            S_JAL: begin
                // JAL retires on its way out of ALUWB, not here.
                ALUSrcA  = 2'b01;
                ALUSrcB  = 2'b10;
                PCUpdate = 1'b1;
                w_next   = S_ALUWB;
            end
            default: w_next = S_FETCH;
        endcase
    end

    assign illegal_instr = r_illegal;
    assign instret       = r_instret;
    assign state_o       = r_state;

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Bench for multicycle_main_fsm: builds each instruction's expected cycle trace from its
// class and stall plan, and checks every cycle against the DUT outputs.
module tb_multicycle_main_fsm;

    localparam int CNT_W = 4;
    localparam int W     = 19 + CNT_W;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [6:0]       opcode;
    logic             mem_ready;
    logic [1:0]       ALUOp, ALUSrcA, ALUSrcB, ResultSrc;
    logic             AdrSrc, IRWrite, PCUpdate, Branch, RegWrite, MemWrite, illegal_instr;
    logic [CNT_W-1:0] instret;
    logic [3:0]       state_o;

    multicycle_main_fsm #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
        .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCUpdate(PCUpdate), .Branch(Branch),
        .RegWrite(RegWrite), .MemWrite(MemWrite), .illegal_instr(illegal_instr),
        .instret(instret), .state_o(state_o)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- model state ----------------
    logic [W-1:0]     exp_q[$];
    logic [CNT_W-1:0] m_instret = '0;
    logic             m_illegal = 1'b0;
    int               n_cmp = 0;
    int               n_fail = 0;

    localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011,
                           OP_I = 7'b0010011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111;

    function automatic logic [W-1:0] exp_vec(input int st, input logic mr);
        logic [3:0] s4;
        logic [1:0] aop, sa, sb, rs;
        logic       adr, irw, pcu, br, rw, mw;
        s4 = st[3:0];
        aop = 2'd0; sa = 2'd0; sb = 2'd0; rs = 2'd0;
        adr = 1'b0; irw = 1'b0; pcu = 1'b0; br = 1'b0; rw = 1'b0; mw = 1'b0;
        case (st)
            0:  begin sb = 2'd2; rs = 2'd2; irw = mr; pcu = mr; end
            1:  begin sa = 2'd1; sb = 2'd1; end
            2:  begin sa = 2'd2; sb = 2'd1; end
            3:  adr = 1'b1;
            4:  begin rs = 2'd1; rw = 1'b1; end
            5:  begin adr = 1'b1; mw = 1'b1; end
            6:  begin sa = 2'd2; aop = 2'd2; end
            7:  begin sa = 2'd2; sb = 2'd1; aop = 2'd2; end
            8:  rw = 1'b1;
            9:  begin sa = 2'd2; aop = 2'd1; br = 1'b1; end
            10: begin sa = 2'd1; sb = 2'd2; pcu = 1'b1; end
            default: ;
        endcase
        return {s4, aop, sa, sb, rs, adr, irw, pcu, br, rw, mw, m_illegal, m_instret};
    endfunction

    // ---------------- scoreboard compare ----------------
    always @(negedge clk) begin
        logic [W-1:0] e, a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {state_o, ALUOp, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, IRWrite, PCUpdate,
                 Branch, RegWrite, MemWrite, illegal_instr, instret};
            n_cmp++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL cycle t=%0t got=%h expected=%h", $time, a, e);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    // Called at posedge+1: drive inputs for the cycle, queue expectation, advance.
    task automatic cycle(input logic mr, input logic [6:0] op, input int st);
        mem_ready = mr;
        opcode    = op;
        exp_q.push_back(exp_vec(st, mr));
        if (st == 0) m_illegal = 1'b0;
        @(posedge clk);
        #1;
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [6:0] rop();
        return 7'($urandom_range(0, 127));
    endfunction

    task automatic run_instr(input logic [6:0] op, input int fstall, input int mstall);
        bit legal = 1'b1;
        for (int i = 0; i < fstall; i++) cycle(1'b0, rop(), 0);
        cycle(1'b1, rop(), 0);
        cycle(rbit(), op, 1);
        case (op)
            OP_LW: begin
                cycle(rbit(), op, 2);
                for (int i = 0; i < mstall; i++) cycle(1'b0, op, 3);
                cycle(1'b1, op, 3);
                cycle(rbit(), op, 4);
            end
            OP_SW: begin
                cycle(rbit(), op, 2);
                for (int i = 0; i < mstall; i++) cycle(1'b0, op, 5);
                cycle(1'b1, op, 5);
            end
            OP_R:   begin cycle(rbit(), op, 6); cycle(rbit(), op, 8); end
            OP_I:   begin cycle(rbit(), op, 7); cycle(rbit(), op, 8); end
            OP_BR:  cycle(rbit(), op, 9);
            OP_JAL: begin cycle(rbit(), op, 10); cycle(rbit(), op, 8); end
            default: begin legal = 1'b0; m_illegal = 1'b1; end
        endcase
        if (legal) m_instret = m_instret + CNT_W'(1);
    endtask

    function automatic logic [6:0] pick_op();
        case ($urandom_range(0, 6))
            0: return OP_LW;
            1: return OP_SW;
            2: return OP_R;
            3: return OP_I;
            4: return OP_BR;
            5: return OP_JAL;
            default: return rop();
        endcase
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        rst_n = 1'b0; mem_ready = 1'b0; opcode = 7'd0;
        #3;
        check("reset_state", 32'(state_o), 32'd0);
        check("reset_instret", 32'(instret), 32'd0);
        check("reset_illegal", 32'(illegal_instr), 32'd0);
        check("reset_irwrite_low", 32'(IRWrite), 32'd0);
        mem_ready = 1'b1;
        #1;
        check("reset_irwrite_follow", 32'(IRWrite), 32'd1);
        check("reset_srcb", 32'(ALUSrcB), 32'd2);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Directed cases from the plan.
        run_instr(OP_R, 0, 0);
        check("rtype_instret", 32'(instret), 32'd1);
        run_instr(OP_LW, 0, 2);
        run_instr(OP_SW, 1, 3);
        run_instr(OP_BR, 0, 0);
        run_instr(OP_JAL, 0, 0);
        check("five_retired", 32'(instret), 32'd5);
        run_instr(7'b0000000, 0, 0);
        check("illegal_pulse", 32'(illegal_instr), 32'd1);
        check("illegal_no_retire", 32'(instret), 32'd5);

        // Asynchronous reset in the middle of a stalled MEMREAD.
        cycle(1'b1, rop(), 0);
        cycle(1'b1, OP_LW, 1);
        cycle(1'b1, OP_LW, 2);
        mem_ready = 1'b0;
        opcode    = OP_LW;
        #1;
        check("pre_reset_memread", 32'(state_o), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_state", 32'(state_o), 32'd0);
        check("async_reset_instret", 32'(instret), 32'd0);
        check("async_reset_irwrite", 32'(IRWrite), 32'd0);
        @(posedge clk);
        #1;
        check("reset_held_state", 32'(state_o), 32'd0);
        rst_n     = 1'b1;
        m_instret = '0;
        m_illegal = 1'b0;

        // Counter wrap from all-ones.
        while (m_instret != {CNT_W{1'b1}}) run_instr(OP_I, 0, 0);
        check("instret_all_ones", 32'(instret), 32'hF);
        run_instr(OP_R, 0, 0);
        check("instret_wrap", 32'(instret), 32'd0);

        // Randomized traffic.
        for (int n = 0; n < 300; n++)
            run_instr(pick_op(), $urandom_range(0, 2), $urandom_range(0, 3));

        cycle(1'b1, rop(), 0);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
